// File: rtl/pipe_adder_if.sv
// Handshake bundle between the ALU operand muxes, the pipelined adder and writeback.
// slave is the adder side; master is the producer/consumer side.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, y, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, y, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, one WIDTH/STAGES slice per stage with registered carry; ADDER_SATURATE_EN clamps y on overflow.
// Latency STAGES cycles from accept to out_valid, one result per cycle.
// Global stall: every rank holds while out_valid && !out_ready; in_ready mirrors the advance enable.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  pipe_adder_if.slave  io
);
  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic advance;

  // Capture rank: holds the operands with B already conditioned for subtract.
  logic             in_vld_r;
  logic [WIDTH-1:0] in_a_r;
  logic [WIDTH-1:0] in_b_r;
  logic             in_cin_r;

  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  r_r [STAGES];
  logic [WIDTH-1:0]  y_r;
  logic              ovf_r;

  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_nxt;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  r_src [STAGES];
  logic [WIDTH-1:0]  r_nxt [STAGES];
  logic [WIDTH-1:0]  y_nxt;
  logic              ovf_nxt;

  function automatic logic [WIDTH-1:0] merge_slice(
    input logic [WIDTH-1:0] base,
    input logic [SW-1:0]    s,
    input int               idx
  );
    logic [WIDTH-1:0] res;
    res = base;
    res[idx*SW +: SW] = s;
    return res;
  endfunction

  assign advance      = !vld_r[LAST] || io.out_ready;
  assign io.in_ready  = advance;
  assign io.out_valid = vld_r[LAST];
  assign io.y         = y_r;
  assign io.cout      = c_r[LAST];
  assign io.ovf       = ovf_r;

  // Operand slices above k ride along untouched; result slices below k are already final.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0] slice_sum;

    if (k == 0) begin : g_head
      assign v_src[k] = in_vld_r;
      assign c_src[k] = in_cin_r;
      assign a_src[k] = in_a_r;
      assign b_src[k] = in_b_r;
      assign r_src[k] = '0;
    end else begin : g_tail
      assign v_src[k] = vld_r[k-1];
      assign c_src[k] = c_r[k-1];
      assign a_src[k] = a_r[k-1];
      assign b_src[k] = b_r[k-1];
      assign r_src[k] = r_r[k-1];
    end

    assign slice_sum = {1'b0, a_src[k][k*SW +: SW]}
                     + {1'b0, b_src[k][k*SW +: SW]}
                     + {{SW{1'b0}}, c_src[k]};
    assign c_nxt[k]  = slice_sum[SW];
    assign r_nxt[k]  = merge_slice(r_src[k], slice_sum[SW-1:0], k);
  end

  assign ovf_nxt = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1])
                && (r_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

`ifdef ADDER_SATURATE_EN
  // Overflow direction follows the sign of A, so A's MSB picks the rail.
  assign y_nxt = !ovf_nxt ? r_nxt[LAST]
               : a_src[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
               : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign y_nxt = r_nxt[LAST];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_vld_r <= 1'b0;
      in_a_r   <= '0;
      in_b_r   <= '0;
      in_cin_r <= 1'b0;
      vld_r    <= '0;
      c_r      <= '0;
      y_r      <= '0;
      ovf_r    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        r_r[k] <= '0;
      end
    end else if (advance) begin
      in_vld_r <= io.in_valid;
      in_a_r   <= io.a;
      in_b_r   <= io.sub ? ~io.b : io.b;
      in_cin_r <= io.sub;
      vld_r    <= v_src;
      c_r      <= c_nxt;
      y_r      <= y_nxt;
      ovf_r    <= ovf_nxt;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= a_src[k];
        b_r[k] <= b_src[k];
        r_r[k] <= r_nxt[k];
      end
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: driver pushes model results on accept, monitor pops on each output transfer.
module tb_pipe_adder;
  localparam int W = 32;
  localparam int N = 4;

`ifdef ADDER_SATURATE_EN
  localparam logic [W-1:0] OVF_POS_Y = 32'h7FFFFFFF;
  localparam logic [W-1:0] OVF_NEG_Y = 32'h80000000;
`else
  localparam logic [W-1:0] OVF_POS_Y = 32'h80000000;
  localparam logic [W-1:0] OVF_NEG_Y = 32'h7FFFFFFF;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus ();

  pipe_adder #(.WIDTH(W), .STAGES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  logic done_rand;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on wide values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb, r;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = s ? (sa - sb) : (sa + sb);
    e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.c = s ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
    e.y = r[W-1:0];
`ifdef ADDER_SATURATE_EN
    if (e.o) e.y = (r > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFFFFFF;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset_n) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.sub));
  end

  exp_t e_pop;
  exp_t held;
  logic stalled = 1'b0;
  always @(negedge clk) begin
    if (!reset_n || !bus.out_valid) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_y", bus.y, held.y);
        chk("hold_cout", bus.cout, held.c);
        chk("hold_ovf", bus.ovf, held.o);
      end
      held    = {bus.y, bus.cout, bus.ovf};
      stalled = !bus.out_ready;
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got y=0x%08h required no output", bus.y);
        end else begin
          e_pop = exp_q.pop_front();
          chk("sb_y", bus.y, e_pop.y);
          chk("sb_cout", bus.cout, e_pop.c);
          chk("sb_ovf", bus.ovf, e_pop.o);
          n_out++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
    int t = 0;
    bus.a = aa;
    bus.b = bb;
    bus.sub = s;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic single_op(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic s, input logic [W-1:0] ey, input logic ec, input logic eo);
    send(aa, bb, s);
    repeat (4) @(negedge clk);
    chk({name, "_early_vld"}, bus.out_valid, 0);
    @(negedge clk);
    chk({name, "_vld"}, bus.out_valid, 1);
    chk({name, "_y"}, bus.y, ey);
    chk({name, "_cout"}, bus.cout, ec);
    chk({name, "_ovf"}, bus.ovf, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] y0;
    int base;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    done_rand     = 1'b0;
    reset_n       = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Back-to-back basic adds with exact latency.
    send(32'd5, 32'd6, 1'b0);
    send(32'd6, 32'd9, 1'b0);
    repeat (3) @(negedge clk);
    chk("basic_early_vld", bus.out_valid, 0);
    @(negedge clk);
    chk("basic0_vld", bus.out_valid, 1);
    chk("basic0_y", bus.y, 32'd11);
    chk("basic0_cout", bus.cout, 0);
    chk("basic0_ovf", bus.ovf, 0);
    @(negedge clk);
    chk("basic1_vld", bus.out_valid, 1);
    chk("basic1_y", bus.y, 32'd15);
    chk("basic1_cout", bus.cout, 0);
    chk("basic1_ovf", bus.ovf, 0);
    @(posedge clk);
    #1;

    single_op("carry", 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    single_op("ovf_add", 32'h7FFFFFFF, 32'd1, 1'b0, OVF_POS_Y, 1'b0, 1'b1);
    single_op("sub", 32'd5, 32'd6, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    single_op("ovf_sub", 32'h80000000, 32'd1, 1'b1, OVF_NEG_Y, 1'b1, 1'b1);

    // Backpressure: 3-cycle stall mid-stream.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        y0 = bus.y;
        chk("stall_y0", y0, 32'd2);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_out_valid", bus.out_valid, 1);
          chk("stall_y", bus.y, y0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - base, 8);

    // Reset with three operations in flight.
    send($urandom, $urandom, 1'b0);
    send($urandom, $urandom, 1'b1);
    send($urandom, $urandom, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_y", bus.y, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    base = n_out;
    repeat (8) @(negedge clk);
    chk("midrst_no_stale", n_out - base, 0);
    chk("midrst_idle_vld", bus.out_valid, 0);
    @(posedge clk);
    #1;
    single_op("post_rst", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0);

    // Random traffic with random consumer backpressure.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("rand_count", n_out - base, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
